// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a byte FIFO and sends each byte as an 8N1 frame, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       rd,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rd_q, rd_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE:  if (tx_en && !fifo_empty) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                // FIFO data is valid one cycle after the read strobe
                shift_d = fifo_data;
                cnt_d   = '0;
                state_d = START;
`ifdef UART_TX_PARITY_EN
                par_d   = ^fifo_data;
`endif
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so every pin comes straight off a flop
        rd_d   = (state_d == FETCH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CNT_MAX);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            rd_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign rd      = rd_q;
    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a byte-FIFO model feeds the DUT and every serial frame is
// compared cycle by cycle against a bit list built from the byte value.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       rd, tx, tx_busy, tx_done;

    int checks = 0;
    int errors = 0;

    // FIFO model: writes from the stimulus process, reads owned by the clocked block
    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int rd_bad = 0;
    int done_cnt = 0;
    int cyc = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .rd(rd), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (rd === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_empty) rd_bad <= rd_bad + 1;
            else begin
                fifo_data <= mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Serial level of bit slot k of the frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ($countones(b) % 2) == 1;
`endif
        return 1'b1;
    endfunction

    // Waits for a start bit, then checks tx/tx_busy/tx_done over the whole frame.
    // drop_at >= 0 lowers tx_en at that cycle of the frame.
    task automatic check_frame(input logic [7:0] b, input int drop_at, input string name,
                               output int t_start, output int t_end);
        int n = 0;
        int bad_tx = 0, bad_busy = 0, dones = 0, bad_done = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            $display("FAIL %s start: tx=%b never went low within 200 cycles", name, tx);
            errors++;
            t_start = cyc;
            t_end = cyc;
            return;
        end
        t_start = cyc;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i == drop_at) tx_en = 1'b0;
            if (tx !== frame_bit(b, i / CPB)) bad_tx++;
            if (tx_busy !== 1'b1) bad_busy++;
            if (tx_done === 1'b1) begin
                dones++;
                if (i != FRAME - 1) bad_done++;
            end
        end
        t_end = cyc;
        checks++;
        if (bad_tx != 0) begin
            $display("FAIL %s tx: byte %h had %0d wrong cycles, required 0", name, b, bad_tx);
            errors++;
        end
        checks++;
        if (bad_busy != 0) begin
            $display("FAIL %s tx_busy: low in %0d frame cycles, required 0", name, bad_busy);
            errors++;
        end
        checks++;
        if (dones != 1 || bad_done != 0) begin
            $display("FAIL %s tx_done: %0d pulses (%0d misplaced), required 1 on last cycle",
                     name, dones, bad_done);
            errors++;
        end
    endtask

    task automatic idle_watch(input int ncyc, input string name);
        int bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (rd !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL %s: %0d cycles with rd/tx/tx_busy not 0/1/0", name, bad);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd, tx, tx_busy, tx_done} !== 4'b0100) begin
            $display("FAIL reset: rd,tx,busy,done=%b required 0100", {rd, tx, tx_busy, tx_done});
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_disabled();
        tx_en = 1'b1;
        idle_watch(100, "empty_enabled");
        tx_en = 1'b0;
        push(8'h3C);
        idle_watch(100, "byte_disabled");
        checks++;
        if (rd_cnt != 0 || wr_ptr - rd_ptr != 1) begin
            $display("FAIL disabled_fifo: rd pulses %0d, bytes left %0d, required 0 and 1",
                     rd_cnt, wr_ptr - rd_ptr);
            errors++;
        end
        tx_en = 1'b1;
        begin
            int ts, te;
            check_frame(8'h3C, -1, "enable_later", ts, te);
        end
    endtask

    task automatic test_single();
        int ts, te, rd0, dn0;
        repeat (5) @(negedge clk);
        rd0 = rd_cnt;
        dn0 = done_cnt;
        push(8'hA5);
        check_frame(8'hA5, -1, "single_a5", ts, te);
        repeat (3) @(negedge clk);
        checks++;
        if (rd_cnt - rd0 != 1 || done_cnt - dn0 != 1 || tx !== 1'b1 || tx_busy !== 1'b0) begin
            $display("FAIL single_end: rd %0d done %0d tx %b busy %b, required 1 1 1 0",
                     rd_cnt - rd0, done_cnt - dn0, tx, tx_busy);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int ts1, te1, ts2, te2, rd0, dn0;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        push(8'h01);
        push(8'hFF);
        check_frame(8'h01, -1, "b2b_first", ts1, te1);
        check_frame(8'hFF, -1, "b2b_second", ts2, te2);
        checks++;
        if (ts2 - te1 - 1 != 3) begin
            $display("FAIL b2b_gap: %0d idle cycles, required 3", ts2 - te1 - 1);
            errors++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rd_cnt - rd0 != 2 || done_cnt - dn0 != 2 || !fifo_empty) begin
            $display("FAIL b2b_counts: rd %0d done %0d empty %b, required 2 2 1",
                     rd_cnt - rd0, done_cnt - dn0, fifo_empty);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [7:0] bytes [6];
        int ts, te, prev_te;
        tx_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            push(bytes[i]);
        end
        @(negedge clk);
        tx_en = 1'b1;
        prev_te = 0;
        for (int i = 0; i < 6; i++) begin
            check_frame(bytes[i], -1, $sformatf("rand%0d", i), ts, te);
            if (i > 0) begin
                checks++;
                if (ts - prev_te - 1 != 3) begin
                    $display("FAIL rand_gap%0d: %0d idle cycles, required 3", i, ts - prev_te - 1);
                    errors++;
                end
            end
            prev_te = te;
        end
    endtask

    task automatic test_en_drop();
        int ts, te, rd0;
        logic [7:0] b0;
        repeat (5) @(negedge clk);
        tx_en = 1'b0;
        b0 = 8'($urandom_range(0, 255));
        push(b0);
        push(8'($urandom_range(0, 255)));
        push(8'h6B);
        rd0 = rd_cnt;
        @(negedge clk);
        tx_en = 1'b1;
        check_frame(b0, 3 * CPB, "en_drop", ts, te);
        repeat (30) @(negedge clk);
        checks++;
        if (rd_cnt - rd0 != 1 || wr_ptr - rd_ptr != 2 || tx_busy !== 1'b0) begin
            $display("FAIL en_drop_after: rd %0d left %0d busy %b, required 1 2 0",
                     rd_cnt - rd0, wr_ptr - rd_ptr, tx_busy);
            errors++;
        end
    endtask

    // Second queued byte is cut off mid-frame by reset; the third must follow cleanly
    task automatic test_reset_mid();
        int n = 0;
        int ts, te;
        tx_en = 1'b1;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            $display("FAIL rst_mid_start: tx=%b never went low", tx);
            errors++;
        end
        repeat (4 * CPB + 1) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || rd !== 1'b0 || tx_busy !== 1'b0) begin
            $display("FAIL rst_mid_async: tx %b rd %b busy %b, required 1 0 0", tx, rd, tx_busy);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(8'h6B, -1, "after_reset", ts, te);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int ts, te;
        repeat (5) @(negedge clk);
        tx_en = 1'b1;
        push(8'hA5);
        push(8'h07);
        check_frame(8'hA5, -1, "parity_a5", ts, te);
        check_frame(8'h07, -1, "parity_07", ts, te);
    endtask
`endif

    initial begin
        test_reset();
        test_empty_disabled();
        test_single();
        test_back_to_back();
        test_random();
        test_en_drop();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (10) @(negedge clk);
        checks++;
        if (rd_bad != 0) begin
            $display("FAIL rd_while_empty: %0d strobes, required 0", rd_bad);
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
